// File: rtl/axis_uart_param_top.sv
// AXI-Stream UART: TX engine, RX engine with glitch rejection, FWFT RX FIFO.
// Configurable data width, parity and stop bits.
module axis_uart_param_top #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  rx_i,
    output logic                  tx_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [1:0]            m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow_o
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYC);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYC / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // Reset asserts asynchronously, releases on the clock.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t                tx_state, tx_next;
    logic [CW-1:0]         tx_cnt;
    logic [BW-1:0]         tx_bit;
    logic                  tx_stop;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_tick, tx_fire, tx_stop_last;

    assign tx_tick      = (tx_cnt == CNT_LAST);
    assign tx_fire      = s_axis_tvalid & s_axis_tready;
    assign tx_stop_last = (STOP_BITS == 1) | tx_stop;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            S_IDLE:  if (tx_fire) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:
                if (tx_tick && tx_bit == BIT_LAST)
                    tx_next = (PARITY == 0) ? S_STOP : S_PAR;
            S_PAR:   if (tx_tick) tx_next = S_STOP;
            S_STOP:  if (tx_tick && tx_stop_last) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_o          = 1'b1;
        s_axis_tready = 1'b0;
        unique case (tx_state)
            S_IDLE:  s_axis_tready = 1'b1;
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = tx_data[tx_bit];
            S_PAR:   tx_o = ^tx_data ^ ODD;
            default: tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_stop <= 1'b0;
            tx_data <= '0;
        end else begin
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + 1'b1;
            if (tx_fire) tx_data <= s_axis_tdata;
            if (tx_tick && tx_state == S_DATA)
                tx_bit <= (tx_bit == BIT_LAST) ? '0 : tx_bit + 1'b1;
            if (tx_tick && tx_state == S_STOP)
                tx_stop <= ~tx_stop_last;
        end
    end

    logic                  rx_s1, rx_s2, rx_s3;
    state_t                rx_state, rx_next;
    logic [CW-1:0]         rx_cnt;
    logic [BW-1:0]         rx_bit;
    logic                  rx_stop, rx_perr, rx_ferr, rx_brk;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_fall, rx_adv, rx_stop_last, rx_push;
    logic [EW-1:0]         rx_word;

    assign rx_fall      = rx_s3 & ~rx_s2;
    assign rx_stop_last = (STOP_BITS == 1) | rx_stop;
    assign rx_adv = (rx_state == S_START) ? (rx_cnt == CNT_HALF)
                                          : (rx_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE:  if (rx_fall && !rx_brk) rx_next = S_START;
            S_START: if (rx_adv) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_adv && rx_bit == BIT_LAST)
                    rx_next = (PARITY == 0) ? S_STOP : S_PAR;
            S_PAR:   if (rx_adv) rx_next = S_STOP;
            S_STOP:  if (rx_adv && rx_stop_last) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rx_state == S_STOP) && rx_adv && rx_stop_last;
        rx_word = {rx_data, rx_ferr | ~rx_s2, rx_perr};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_stop <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            rx_brk  <= 1'b0;
            rx_data <= '0;
        end else begin
            if (rx_state == S_IDLE || rx_adv) rx_cnt <= '0;
            else                              rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_IDLE) begin
                rx_bit  <= '0;
                rx_stop <= 1'b0;
                rx_perr <= 1'b0;
                rx_ferr <= 1'b0;
                if (rx_s2) rx_brk <= 1'b0;
            end
            if (rx_adv && rx_state == S_DATA) begin
                rx_data[rx_bit] <= rx_s2;
                rx_bit <= (rx_bit == BIT_LAST) ? '0 : rx_bit + 1'b1;
            end
            if (rx_adv && rx_state == S_PAR)
                rx_perr <= (PARITY != 0) && (rx_s2 != (^rx_data ^ ODD));
            if (rx_adv && rx_state == S_STOP) begin
                if (!rx_s2) rx_ferr <= 1'b1;
                rx_stop <= ~rx_stop_last;
            end
            // A line still low at the end of the frame is a break.
            if (rx_push) rx_brk <= ~rx_s2;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, wr_en;
    logic [EW-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = m_axis_tvalid & m_axis_tready;
    assign wr_en = rx_push & (~full | pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? '0 : head[EW-1:2];
    assign m_axis_tuser  = empty ? '0 : head[1:0];

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_word;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overflow_o <= rx_push & full & ~pop;
        end
    end

endmodule

// File: tb/tb_axis_uart_param_top.sv
// Directed bench: default-rate instance for TX timing, glitch and reset;
// fast-rate even-parity 2-stop instance for loopback, errors and FIFO.
module tb_axis_uart_param_top;

    localparam int B0 = 234;
    localparam int B1 = 8;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic       rx0 = 1'b1, tx0;
    logic [7:0] s0_tdata = '0, m0_tdata;
    logic       s0_tvalid = 1'b0, s0_tready;
    logic [1:0] m0_tuser;
    logic       m0_tvalid, m0_tready = 1'b1, ovf0;

    axis_uart_param_top dut0 (
        .clk_i(clk), .arstn_i(arstn), .rx_i(rx0), .tx_o(tx0),
        .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid),
        .s_axis_tready(s0_tready), .m_axis_tdata(m0_tdata),
        .m_axis_tuser(m0_tuser), .m_axis_tvalid(m0_tvalid),
        .m_axis_tready(m0_tready), .overflow_o(ovf0)
    );

    logic       rx1, tx1, lb = 1'b0, rx_drv = 1'b1;
    logic [7:0] s1_tdata = '0, m1_tdata;
    logic       s1_tvalid = 1'b0, s1_tready;
    logic [1:0] m1_tuser;
    logic       m1_tvalid, m1_tready = 1'b1, ovf1;

    assign rx1 = lb ? tx1 : rx_drv;

    axis_uart_param_top #(
        .CLK_FREQ(800_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut1 (
        .clk_i(clk), .arstn_i(arstn), .rx_i(rx1), .tx_o(tx1),
        .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid),
        .s_axis_tready(s1_tready), .m_axis_tdata(m1_tdata),
        .m_axis_tuser(m1_tuser), .m_axis_tvalid(m1_tvalid),
        .m_axis_tready(m1_tready), .overflow_o(ovf1)
    );

    logic [9:0] rxq[$];
    int         ovf1_cnt = 0;

    always @(negedge clk) begin
        if (m1_tvalid && m1_tready) rxq.push_back({m1_tuser, m1_tdata});
        if (ovf1) ovf1_cnt++;
    end

    function automatic logic [9:0] q_at(input int i);
        return (i < rxq.size()) ? rxq[i] : 10'h3ff;
    endfunction

    task automatic bit1(input logic b);
        rx_drv = b;
        repeat (B1) @(posedge clk);
    endtask

    task automatic frame1(input logic [7:0] d, input logic p,
                          input logic s1, input logic s2);
        bit1(1'b0);
        for (int i = 0; i < 8; i++) bit1(d[i]);
        bit1(p);
        bit1(s1);
        bit1(s2);
    endtask

    task automatic wait_rx(input int n, input int lim);
        for (int i = 0; i < lim && rxq.size() < n; i++) @(posedge clk);
        #1;
        check("rx_count", rxq.size(), n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        logic [7:0] d;
        int low;
        int to;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx0, 1);
        check("rst_tready", s0_tready, 1);
        check("rst_tvalid", m0_tvalid, 0);
        check("rst_tdata", m0_tdata, 0);
        check("rst_tuser", m0_tuser, 0);
        check("rst_ovf", ovf0, 0);
        #2 arstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // TX 0xA5, 8N1 at 234 clk/bit
        fr = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        s0_tdata = 8'hA5;
        s0_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s0_tvalid = 1'b0;
        check("tx_start_now", tx0, 0);
        check("tready_drop", s0_tready, 0);
        low = 0;
        for (int c = 0; c < 2400; c++) begin
            if (c % B0 == B0 / 2 && c < 10 * B0)
                check($sformatf("tx_bit%0d", c / B0), tx0, fr[c / B0]);
            if (!s0_tready) low++;
            @(posedge clk);
            #1;
        end
        check("tready_low", low, 2340);

        // 50-clk glitch must not start a frame
        rx0 = 1'b0;
        repeat (50) @(posedge clk);
        rx0 = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("glitch_tvalid", m0_tvalid, 0);

        // loopback 0x00..0xFF, even parity, 2 stop bits
        lb = 1'b1;
        to = 0;
        for (int i = 0; i < 256; i++) begin
            int w;
            s1_tdata = 8'(i);
            s1_tvalid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!s1_tready && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 1000) to++;
            @(posedge clk);
            #1;
        end
        s1_tvalid = 1'b0;
        check("lb_hs_timeout", to, 0);
        wait_rx(256, 2000);
        for (int i = 0; i < 256; i++)
            check($sformatf("lb_%0d", i), q_at(i), {2'b00, 8'(i)});
        check("lb_ovf", ovf1_cnt, 0);
        lb = 1'b0;
        repeat (4) @(posedge clk);

        // 0x01 with wrong even-parity bit
        rxq.delete();
        frame1(8'h01, 1'b0, 1'b1, 1'b1);
        bit1(1'b1);
        wait_rx(1, 200);
        check("par_err", q_at(0), {2'b01, 8'h01});

        // 0x3C with stop bits low and a short break, then a clean frame
        rxq.delete();
        frame1(8'h3C, 1'b0, 1'b0, 1'b0);
        bit1(1'b0);
        bit1(1'b0);
        bit1(1'b1);
        bit1(1'b1);
        frame1(8'h5A, 1'b0, 1'b1, 1'b1);
        bit1(1'b1);
        wait_rx(2, 200);
        check("frame_err", q_at(0), {2'b10, 8'h3C});
        check("after_break", q_at(1), {2'b00, 8'h5A});

        // FIFO depth 4 overflow
        rxq.delete();
        ovf1_cnt = 0;
        m1_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            frame1(d, ^d, 1'b1, 1'b1);
            bit1(1'b1);
        end
        repeat (20) @(posedge clk);
        #1;
        check("ovf_pulses", ovf1_cnt, 1);
        check("full_tvalid", m1_tvalid, 1);
        check("full_head", {m1_tuser, m1_tdata}, {2'b00, 8'h11});
        m1_tready = 1'b1;
        wait_rx(4, 100);
        for (int i = 0; i < 4; i++)
            check($sformatf("fifo_%0d", i), q_at(i),
                  {2'b00, 8'h11 + 8'(i)});
        repeat (10) @(posedge clk);
        #1;
        check("fifo_drained", rxq.size(), 4);
        check("fifo_empty", m1_tvalid, 0);

        // reset during TX data bit 3
        @(negedge clk);
        s0_tdata = 8'hA5;
        s0_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s0_tvalid = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        check("tx_pre_rst", tx0, 0);
        #2 arstn = 1'b0;
        #1;
        check("tx_rst_async", tx0, 1);
        repeat (3) @(posedge clk);
        #2 arstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("tready_post_rst", s0_tready, 1);
        check("tx_post_rst", tx0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
